// File: rtl/fp32_pkg.sv
// Shared single-precision float definitions for the sequential FP units.
// Holds the fp32 constants, the divider state encoding and the special-case
// bundle produced by fp32_classify.
package fp32_pkg;

    localparam int          FP32_BIAS    = 127;
    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
    localparam logic [30:0] FP32_INF_MAG = 31'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } divf_state_t;

    // Precomputed result for an operand pair that bypasses the datapath.
    typedef struct packed {
        logic [31:0] s;
        logic        dz;
        logic        inv;
    } fp32_special_t;

endpackage

// File: rtl/divf_seq_if.sv
// Handshake/data bundle of the sequential fp32 divider.
//   start, a, b            : request and operands (requester -> divider)
//   busy, done, s, flags   : status, quotient and exception flags (divider -> requester)
// master = requester side, slave = divider side.
interface divf_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] s;
    logic        dz;
    logic        inv;
    logic        ovf;
    logic        unf;

    modport master (
        output start, a, b,
        input  busy, done, s, dz, inv, ovf, unf
    );

    modport slave (
        input  start, a, b,
        output busy, done, s, dz, inv, ovf, unf
    );
endinterface

// File: rtl/fp32_classify.sv
// Combinational operand classifier for fp32 divide (and later multiply).
// Ports:
//   a, b          : fp32 operands
//   a_nan_inf     : a exponent all ones      b_nan_inf : same for b
//   a_zero        : a exponent zero (denormals flush to zero)   b_zero : same for b
//   special       : encoded result and dz/inv flags for the special pair;
//                   only meaningful when one of the four class bits is set.
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [31:0]   a,
    input  logic [31:0]   b,
    output logic          a_nan_inf,
    output logic          b_nan_inf,
    output logic          a_zero,
    output logic          b_zero,
    output fp32_special_t special
);

    logic sign;

    assign a_nan_inf = (a[30:23] == 8'hFF);
    assign b_nan_inf = (b[30:23] == 8'hFF);
    assign a_zero    = (a[30:23] == 8'h00);
    assign b_zero    = (b[30:23] == 8'h00);
    assign sign      = a[31] ^ b[31];

    // Priority: NaN/Inf operand, then 0/0, then x/0, then 0/x.
    always_comb begin
        special.s   = {sign, 31'd0};
        special.dz  = 1'b0;
        special.inv = 1'b0;
        if (a_nan_inf || b_nan_inf) begin
            special.s   = FP32_QNAN;
            special.inv = 1'b1;
        end else if (a_zero && b_zero) begin
            special.s   = FP32_QNAN;
            special.inv = 1'b1;
        end else if (b_zero) begin
            special.s  = {sign, FP32_INF_MAG};
            special.dz = 1'b1;
        end
    end

endmodule

// File: rtl/divf_seq.sv
// Multi-cycle fp32 divider with start/busy/done handshake.
// The quotient significand comes from a restoring shift-subtract loop that
// produces one bit per clock, then a single normalise/pack cycle.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : divf_seq_if.slave (start, a, b in; busy, done, s, dz, inv, ovf, unf out)
// Parameters:
//   QBITS  : quotient bits per operation; only 25 (fp32) is supported
//   BIAS   : exponent bias
module divf_seq
    import fp32_pkg::*;
#(
    parameter int QBITS = 25,
    parameter int BIAS  = FP32_BIAS
)
(
    input  logic      clk,
    input  logic      rst_n,
    divf_seq_if.slave bus
);

    divf_state_t   state_reg, state_next;
    logic [24:0]   rem_reg, rem_next;
    logic [24:0]   quo_reg, quo_next;
    logic [4:0]    cnt_reg, cnt_next;
    logic [23:0]   mb_reg, mb_next;
    logic [7:0]    a_exp_reg, a_exp_next;
    logic [7:0]    b_exp_reg, b_exp_next;
    logic          sign_reg, sign_next;
    logic          special_reg, special_next;
    fp32_special_t spec_reg, spec_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic [31:0]   s_reg, s_next;
    logic          dz_reg, dz_next;
    logic          inv_reg, inv_next;
    logic          ovf_reg, ovf_next;
    logic          unf_reg, unf_next;

    logic          a_nan_inf, b_nan_inf, a_zero, b_zero;
    fp32_special_t special_cls;
    logic          accept;
    logic [23:0]   diff;
    logic signed [9:0] e_raw;
    logic signed [9:0] e_adj;
    logic [22:0]   mant;

    fp32_classify u_classify (
        .a         (bus.a),
        .b         (bus.b),
        .a_nan_inf (a_nan_inf),
        .b_nan_inf (b_nan_inf),
        .a_zero    (a_zero),
        .b_zero    (b_zero),
        .special   (special_cls)
    );

    // The done cycle is spent in IDLE with done_reg high; starts seen during
    // that cycle are dropped so a held start restarts one edge later.
    assign accept = (state_reg == IDLE) && bus.start && !done_reg;

    // Remainder stays below 2*mb, so when R >= mb the difference fits 24 bits.
    assign diff = rem_reg[23:0] - mb_reg;

    // Exponent of the quotient, then normalise on the quotient's top bit.
    always_comb begin
        e_raw = signed'({2'b00, a_exp_reg}) - signed'({2'b00, b_exp_reg}) + signed'(10'(BIAS));
        e_adj = e_raw;
        mant  = quo_reg[23:1];
        if (!quo_reg[24]) begin
            mant  = quo_reg[22:0];
            e_adj = e_raw - 10'sd1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rem_next     = rem_reg;
        quo_next     = quo_reg;
        cnt_next     = cnt_reg;
        mb_next      = mb_reg;
        a_exp_next   = a_exp_reg;
        b_exp_next   = b_exp_reg;
        sign_next    = sign_reg;
        special_next = special_reg;
        spec_next    = spec_reg;
        busy_next    = busy_reg;
        done_next    = done_reg;
        s_next       = s_reg;
        dz_next      = dz_reg;
        inv_next     = inv_reg;
        ovf_next     = ovf_reg;
        unf_next     = unf_reg;

        case (state_reg)
            IDLE: begin
                done_next = 1'b0;
                if (accept) begin
                    a_exp_next   = bus.a[30:23];
                    b_exp_next   = bus.b[30:23];
                    sign_next    = bus.a[31] ^ bus.b[31];
                    mb_next      = {1'b1, bus.b[22:0]};
                    rem_next     = {2'b01, bus.a[22:0]};
                    quo_next     = '0;
                    cnt_next     = '0;
                    special_next = a_nan_inf | b_nan_inf | a_zero | b_zero;
                    spec_next    = special_cls;
                    busy_next    = 1'b1;
                    dz_next      = 1'b0;
                    inv_next     = 1'b0;
                    ovf_next     = 1'b0;
                    unf_next     = 1'b0;
                    state_next   = (a_nan_inf | b_nan_inf | a_zero | b_zero) ? NORM : DIV;
                end
            end

            DIV: begin
                if (rem_reg >= {1'b0, mb_reg}) begin
                    quo_next = {quo_reg[23:0], 1'b1};
                    rem_next = {diff, 1'b0};
                end else begin
                    quo_next = {quo_reg[23:0], 1'b0};
                    rem_next = {rem_reg[23:0], 1'b0};
                end
                cnt_next = cnt_reg + 5'd1;
                if (cnt_reg == 5'(QBITS - 1)) begin
                    state_next = NORM;
                end
            end

            NORM: begin
                if (special_reg) begin
                    s_next   = spec_reg.s;
                    dz_next  = spec_reg.dz;
                    inv_next = spec_reg.inv;
                end else if (e_adj >= 10'sd255) begin
                    s_next   = {sign_reg, FP32_INF_MAG};
                    ovf_next = 1'b1;
                end else if (e_adj <= 10'sd0) begin
                    s_next   = {sign_reg, 31'd0};
                    unf_next = 1'b1;
                end else begin
                    s_next   = {sign_reg, e_adj[7:0], mant};
                end
                state_next = DONE;
            end

            DONE: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            rem_reg     <= '0;
            quo_reg     <= '0;
            cnt_reg     <= '0;
            mb_reg      <= '0;
            a_exp_reg   <= '0;
            b_exp_reg   <= '0;
            sign_reg    <= 1'b0;
            special_reg <= 1'b0;
            spec_reg    <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            s_reg       <= '0;
            dz_reg      <= 1'b0;
            inv_reg     <= 1'b0;
            ovf_reg     <= 1'b0;
            unf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            cnt_reg     <= cnt_next;
            mb_reg      <= mb_next;
            a_exp_reg   <= a_exp_next;
            b_exp_reg   <= b_exp_next;
            sign_reg    <= sign_next;
            special_reg <= special_next;
            spec_reg    <= spec_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            s_reg       <= s_next;
            dz_reg      <= dz_next;
            inv_reg     <= inv_next;
            ovf_reg     <= ovf_next;
            unf_reg     <= unf_next;
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.s    = s_reg;
    assign bus.dz   = dz_reg;
    assign bus.inv  = inv_reg;
    assign bus.ovf  = ovf_reg;
    assign bus.unf  = unf_reg;

endmodule

// File: tb/tb_divf_seq.sv
// Self-checking bench for divf_seq: directed cases, randomized operands
// against an arithmetic reference model, handshake and reset scenarios.
module tb_divf_seq;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    divf_seq_if bus ();

    divf_seq #(.QBITS(25), .BIAS(127)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer quotient of the significands, truncated.
    // fl = {dz, inv, ovf, unf}; lat_o = edges from accept to done.
    function automatic void ref_div(input logic [31:0] av, input logic [31:0] bv,
                                    output logic [31:0] s_o, output logic [3:0] fl,
                                    output int lat_o);
        int ae, be, e;
        logic sg;
        longint ma, mb, q;
        logic [22:0] mant;
        logic [7:0] e8;
        ae = int'(av[30:23]);
        be = int'(bv[30:23]);
        sg = av[31] ^ bv[31];
        fl = 4'b0000;
        lat_o = 2;
        s_o = {sg, 31'd0};
        if (ae == 255 || be == 255) begin
            s_o = 32'h7FC00000; fl = 4'b0100;
        end else if (ae == 0 && be == 0) begin
            s_o = 32'h7FC00000; fl = 4'b0100;
        end else if (be == 0) begin
            s_o = {sg, 31'h7F800000}; fl = 4'b1000;
        end else if (ae == 0) begin
            s_o = {sg, 31'd0};
        end else begin
            lat_o = 27;
            ma = longint'({1'b1, av[22:0]});
            mb = longint'({1'b1, bv[22:0]});
            q  = (ma << 24) / mb;
            e  = ae - be + 127;
            if (q >= (longint'(1) << 24)) begin
                mant = 23'(q >> 1);
            end else begin
                mant = 23'(q);
                e = e - 1;
            end
            if (e >= 255) begin
                s_o = {sg, 31'h7F800000}; fl = 4'b0010;
            end else if (e <= 0) begin
                s_o = {sg, 31'd0}; fl = 4'b0001;
            end else begin
                e8 = 8'(e);
                s_o = {sg, e8, mant};
            end
        end
    endfunction

    // One full operation from an idle divider; returns observations.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] s_o, output logic [3:0] fl,
                         output int lat, output int busy_n, output logic done_after);
        bus.a = av;
        bus.b = bv;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_n = bus.busy ? 1 : 0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = c;
                break;
            end
            if (bus.busy) busy_n++;
        end
        s_o = bus.s;
        fl  = {bus.dz, bus.inv, bus.ovf, bus.unf};
        @(posedge clk); #1;
        done_after = bus.done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.busy, bus.done, bus.s, bus.dz, bus.inv, bus.ovf, bus.unf} !== 38'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b s=%h flags=%b%b%b%b, want all 0",
                     bus.busy, bus.done, bus.s, bus.dz, bus.inv, bus.ovf, bus.unf);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset released");
    endtask

    localparam int ND = 9;
    localparam logic [31:0] TA [ND] = '{32'h40C00000, 32'h3F800000, 32'hC0C00000, 32'hBF800000,
                                        32'h00000000, 32'h7F800000, 32'h7F000000, 32'h00800000,
                                        32'h00000000};
    localparam logic [31:0] TB [ND] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h00000000,
                                        32'h00000000, 32'h3F800000, 32'h3E800000, 32'h40000000,
                                        32'hC0000000};
    localparam logic [31:0] TS [ND] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000, 32'hFF800000,
                                        32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000,
                                        32'h80000000};
    localparam logic [3:0]  TF [ND] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000,
                                        4'b0100, 4'b0100, 4'b0010, 4'b0001,
                                        4'b0000};
    localparam int          TL [ND] = '{27, 27, 27, 2, 2, 2, 27, 27, 2};

    task automatic test_directed();
        logic [31:0] s_o;
        logic [3:0] fl;
        int lat, busy_n;
        logic done_after;
        for (int i = 0; i < ND; i++) begin
            do_op(TA[i], TB[i], s_o, fl, lat, busy_n, done_after);
            $display("directed %0d: a=%h b=%h s=%h flags=%b lat=%0d busy=%0d", i, TA[i], TB[i], s_o, fl, lat, busy_n);
            n_vec++;
            if (s_o !== TS[i]) begin
                n_bad++; $display("FAIL directed_s[%0d]: got %h want %h", i, s_o, TS[i]);
            end
            n_vec++;
            if (fl !== TF[i]) begin
                n_bad++; $display("FAIL directed_flags[%0d]: got %b want %b", i, fl, TF[i]);
            end
            n_vec++;
            if (lat !== TL[i]) begin
                n_bad++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, TL[i]);
            end
            n_vec++;
            if (busy_n !== TL[i]) begin
                n_bad++; $display("FAIL directed_busy_cycles[%0d]: got %0d want %0d", i, busy_n, TL[i]);
            end
            n_vec++;
            if (done_after !== 1'b0) begin
                n_bad++; $display("FAIL directed_done_pulse[%0d]: got done=%b want 0", i, done_after);
            end
        end
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0] ex;
        int sel;
        sel = int'($urandom_range(0, 11));
        case (sel)
            0:       ex = 8'h00;
            1:       ex = 8'hFF;
            2:       ex = 8'($urandom_range(1, 6));
            3:       ex = 8'($urandom_range(248, 254));
            default: ex = 8'($urandom_range(90, 165));
        endcase
        return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
    endfunction

    task automatic test_random();
        logic [31:0] av, bv, s_o, s_exp;
        logic [3:0] fl, fl_exp;
        int lat, lat_exp, busy_n;
        logic done_after;
        for (int i = 0; i < 40; i++) begin
            av = rand_fp();
            bv = rand_fp();
            ref_div(av, bv, s_exp, fl_exp, lat_exp);
            do_op(av, bv, s_o, fl, lat, busy_n, done_after);
            $display("random %0d: a=%h b=%h s=%h flags=%b lat=%0d", i, av, bv, s_o, fl, lat);
            n_vec++;
            if (s_o !== s_exp) begin
                n_bad++; $display("FAIL random_s[%0d]: a=%h b=%h got %h want %h", i, av, bv, s_o, s_exp);
            end
            n_vec++;
            if (fl !== fl_exp) begin
                n_bad++; $display("FAIL random_flags[%0d]: got %b want %b", i, fl, fl_exp);
            end
            n_vec++;
            if (lat !== lat_exp) begin
                n_bad++; $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, lat_exp);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] s_exp;
        logic [3:0] fl_exp;
        int lat_exp, lat;
        logic busy_seen;
        ref_div(32'h40C00000, 32'h40000000, s_exp, fl_exp, lat_exp);
        bus.a = 32'h40C00000;
        bus.b = 32'h40000000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = 32'h3F800000;
        bus.b = 32'h40400000;
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int c = 6; c <= 60; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        $display("ignore_start: s=%h lat=%0d", bus.s, lat);
        n_vec++;
        if (lat !== lat_exp) begin
            n_bad++; $display("FAIL ignore_latency: got %0d want %0d", lat, lat_exp);
        end
        n_vec++;
        if ({bus.s, bus.dz, bus.inv, bus.ovf, bus.unf} !== {s_exp, fl_exp}) begin
            n_bad++; $display("FAIL ignore_result: got s=%h want %h", bus.s, s_exp);
        end
        busy_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus.busy) busy_seen = 1'b1;
        end
        n_vec++;
        if (busy_seen !== 1'b0) begin
            n_bad++; $display("FAIL ignore_no_second_op: got busy=%b want 0", busy_seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] s1_exp, s2_exp, s1, s2;
        logic [3:0] f1_exp, f2_exp, f1, f2;
        int l1_exp, l2_exp, t1, t2;
        ref_div(32'h40C00000, 32'hC0000000, s1_exp, f1_exp, l1_exp);
        ref_div(32'h41200000, 32'h40E00000, s2_exp, f2_exp, l2_exp);
        bus.a = 32'h40C00000;
        bus.b = 32'hC0000000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.a = 32'h41200000;
        bus.b = 32'h40E00000;
        t1 = -1; t2 = -1; s1 = '0; s2 = '0; f1 = '0; f2 = '0;
        for (int c = 1; c <= 90; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                if (t1 < 0) begin
                    t1 = c; s1 = bus.s; f1 = {bus.dz, bus.inv, bus.ovf, bus.unf};
                end else begin
                    t2 = c; s2 = bus.s; f2 = {bus.dz, bus.inv, bus.ovf, bus.unf};
                    break;
                end
            end
        end
        bus.start = 1'b0;
        $display("back_to_back: s1=%h t1=%0d s2=%h t2=%0d", s1, t1, s2, t2);
        n_vec++;
        if ({s1, f1} !== {s1_exp, f1_exp} || t1 !== l1_exp) begin
            n_bad++; $display("FAIL b2b_first: got s=%h fl=%b t=%0d want s=%h fl=%b t=%0d", s1, f1, t1, s1_exp, f1_exp, l1_exp);
        end
        n_vec++;
        if ({s2, f2} !== {s2_exp, f2_exp}) begin
            n_bad++; $display("FAIL b2b_second: got s=%h fl=%b want s=%h fl=%b", s2, f2, s2_exp, f2_exp);
        end
        // Second request is accepted on the edge right after the done cycle.
        n_vec++;
        if (t2 !== l1_exp + 2 + l2_exp) begin
            n_bad++; $display("FAIL b2b_second_timing: got %0d want %0d", t2, l1_exp + 2 + l2_exp);
        end
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic done_seen, busy_seen;
        logic [31:0] s_o, s_exp;
        logic [3:0] fl, fl_exp;
        int lat, lat_exp, busy_n;
        logic done_after;
        bus.a = 32'h3F800000;
        bus.b = 32'h40400000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.busy, bus.done, bus.s, bus.dz, bus.inv, bus.ovf, bus.unf} !== 38'd0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b s=%h, want all 0", bus.busy, bus.done, bus.s);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        done_seen = 1'b0;
        busy_seen = 1'b0;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk); #1;
            if (bus.done) done_seen = 1'b1;
            if (bus.busy) busy_seen = 1'b1;
        end
        n_vec++;
        if ({done_seen, busy_seen} !== 2'b00) begin
            n_bad++; $display("FAIL reset_mid_abandon: got done=%b busy=%b want 0 0", done_seen, busy_seen);
        end
        ref_div(32'h42C80000, 32'h41200000, s_exp, fl_exp, lat_exp);
        do_op(32'h42C80000, 32'h41200000, s_o, fl, lat, busy_n, done_after);
        $display("after_reset: s=%h flags=%b lat=%0d", s_o, fl, lat);
        n_vec++;
        if ({s_o, fl} !== {s_exp, fl_exp} || lat !== lat_exp) begin
            n_bad++; $display("FAIL reset_mid_fresh_op: got s=%h fl=%b lat=%0d want s=%h fl=%b lat=%0d", s_o, fl, lat, s_exp, fl_exp, lat_exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/divf_seq.md
Name: divf_seq

Overview:
Multi-cycle IEEE-754 single-precision divider with a start/busy/done handshake.
- Computes the quotient mantissa with a restoring shift-subtract loop, one quotient bit per cycle, so no combinational 24-bit divide is needed.
- Replaces the combinational float divide in the ALU datapath wherever timing matters.
- Adds special-case handling and status flags.

Parameters:
- QBITS, 25, quotient bits generated per operation. Covers 24 significand bits plus 1 normalisation bit. Fixed for fp32; any other value is unsupported.
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  32  dividend, fp32
- b  in  32  divisor, fp32
- busy  out  1  high from the edge that accepts start through the edge that raises done
- done  out  1  one-cycle pulse; s and flags are valid from this cycle
- s  out  32  quotient, held until the next accepted start
- dz  out  1  divide-by-zero (finite nonzero / 0)
- inv  out  1  invalid: NaN or Inf operand, or 0/0
- ovf  out  1  exponent overflow; s = signed Inf
- unf  out  1  exponent underflow; s = signed zero

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state = IDLE.
  - busy, done, s, dz, inv, ovf, unf all 0.
  - Internal remainder, quotient and counter all 0.
  - Reset asserted mid-operation abandons the operation; no done is produced.
- States: IDLE, DIV, NORM, DONE.
- IDLE: on start=1 at edge k:
  - Latch a and b.
  - Sign = a[31]^b[31].
  - Mantissas get the implicit 1 prepended: ma = {1,a[22:0]}, mb = {1,b[22:0]}.
  - Remainder R = {0,ma}; quotient Q = 0; counter = 0.
  - busy=1; clear all flags.
  - If the operand pair is special, go to NORM with the special flag set; otherwise go to DIV.
- Special-case classes, in priority order:
  - aexp==255 or bexp==255 -> s=0x7FC00000, inv=1, sign ignored.
  - bexp==0 and aexp==0 -> s=0x7FC00000, inv=1.
  - bexp==0 -> s = {sign, 0x7F800000[30:0]}, dz=1.
  - aexp==0 -> s = {sign, 31'b0}.
  - Denormal operands are flushed to zero, i.e. classified only by exponent == 0.
- DIV: each edge, one restoring step:
  - If R >= {0,mb}: Q = {Q[23:0],1} and R = (R - mb) << 1.
  - Else: Q = {Q[23:0],0} and R = R << 1.
  - counter increments; after QBITS steps (edge k+25) go to NORM.
  - Result: Q = floor(ma * 2^24 / mb), which lies in [2^23, 2^25).
- NORM (one edge):
  - Form a signed 10-bit exponent e = aexp - bexp + BIAS.
  - If Q[24]: mantissa = Q[23:1]; else mantissa = Q[22:0] and e = e - 1.
  - Rounding is truncation; no sticky or round bits.
  - If e >= 255: s = signed Inf, ovf=1.
  - Else if e <= 0: s = signed zero, unf=1.
  - Else s = {sign, e[7:0], mantissa}.
  - Special path: write the precomputed special result instead.
  - Go to DONE.
- DONE (one cycle): done=1, busy=0; next edge returns to IDLE.
- Timing: done is visible after edge k+27 on the normal path and after edge k+2 on the special path.
- start while busy or done is high is ignored; there is no queueing.
- start may be held high: a new operation is accepted on the first IDLE edge.
- a and b may change freely after the accepting edge.
- s and the flags hold their values after done until the next accepted start.

Decomposition:
- Shared package fp32_pkg:
  - Constants FP32_BIAS=127, FP32_QNAN=32'h7FC00000, FP32_INF_MAG=31'h7F800000.
  - State enum type divf_state_t {IDLE, DIV, NORM, DONE}.
- One sub-module, fp32_classify:
  - Combinational; takes a and b.
  - Outputs is_nan_inf, is_zero per operand, and the encoded special result plus flags.
  - Reused by the future sequential multiplier.

Test Plan:
- 6.0/2.0 (a=0x40C00000, b=0x40000000), start at edge k -> done pulse after edge k+27, s=0x40400000, all flags 0, busy high for exactly 27 cycles.
- 1.0/3.0 (0x3F800000/0x40400000) -> s=0x3EAAAAAA (truncated); -6.0/2.0 (0xC0C00000/0x40000000) -> s=0xC0400000.
- -1.0/0 (0xBF800000/0x00000000) -> s=0xFF800000, dz=1, done after edge k+2.
  - 0/0 -> s=0x7FC00000, inv=1, dz=0.
  - Inf/1.0 (0x7F800000/0x3F800000) -> s=0x7FC00000, inv=1.
- Overflow/underflow:
  - 0x7F000000/0x3E800000 -> s=0x7F800000, ovf=1.
  - 0x00800000/0x40000000 -> s=0x00000000, unf=1.
- Handshake robustness:
  - start pulsed again at k+5 with different operands -> ignored; first result is unchanged.
  - start held high through done -> second operation accepted on the IDLE edge.
- Reset mid-operation: rst_n low at k+10 -> busy, done, s and flags 0 immediately; no done afterwards. A fresh start after rst_n rises completes normally.
